// File: rtl/galena_pkg.sv
// Shared types and width helpers for the galena write scheduler.
package galena_pkg;

  // Default macro geometry
  localparam int unsigned NUM_SPIN_DEF = 256;
  localparam int unsigned BIT_DATA_DEF = 4;

  // Word-line and bit-line widths for the default geometry
  localparam int unsigned WWL_WIDTH = NUM_SPIN_DEF + 1;
  localparam int unsigned WBL_WIDTH = NUM_SPIN_DEF * BIT_DATA_DEF;

  // Write scheduler FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // One word line per spin row plus the h row
  function automatic int unsigned wwl_width(input int unsigned num_spin);
    return num_spin + 1;
  endfunction

  // One BIT_DATA-wide weight per spin column
  function automatic int unsigned wbl_width(input int unsigned num_spin,
                                            input int unsigned bit_data);
    return num_spin * bit_data;
  endfunction

  // Largest of the three phase lengths sizes the shared timer
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/galena_phase_timer.sv
// Shared down-counter timing the SETUP, PULSE and HOLD phases.
module galena_phase_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load a new phase length or count down to zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last cycle of the current phase
  assign expire_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/galena_write_sched.sv
// Row-by-row write scheduler driving the WWL/WBL lines of a galena macro.
module galena_write_sched
  import galena_pkg::*;
#(
  parameter int unsigned NUM_SPIN  = NUM_SPIN_DEF,
  parameter int unsigned BIT_DATA  = BIT_DATA_DEF,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic [NUM_SPIN*BIT_DATA-1:0]      row_data_i,
  input  logic                              row_valid_i,
  output logic                              row_ready_o,
  output logic [NUM_SPIN:0]                 wwl_o,
  output logic [NUM_SPIN*BIT_DATA-1:0]      wbl_o,
  output logic [$clog2(NUM_SPIN+1)-1:0]     row_idx_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int unsigned WWL_W = wwl_width(NUM_SPIN);
  localparam int unsigned WBL_W = wbl_width(NUM_SPIN, BIT_DATA);
  localparam int unsigned IDX_W = $clog2(NUM_SPIN + 1);
  localparam int unsigned CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

  state_t             state_q,   state_d;
  logic [IDX_W-1:0]   row_idx_q, row_idx_d;
  logic [WWL_W-1:0]   wwl_q,     wwl_d;
  logic [WBL_W-1:0]   wbl_q,     wbl_d;
  logic               ready_q,   ready_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_expire;

  galena_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_c   (tmr_expire)
  );

  // Next state, row bookkeeping and line drive; abort overrides everything
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    wwl_d     = wwl_q;
    wbl_d     = wbl_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          row_idx_d = '0;
          state_d   = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (row_valid_i) begin
          wbl_d    = row_data_i;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(SETUP_CYC);
        end
      end
      ST_SETUP: begin
        if (tmr_expire) begin
          wwl_d    = WWL_W'(1) << row_idx_q;
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(PULSE_CYC);
        end
      end
      ST_PULSE: begin
        if (tmr_expire) begin
          wwl_d    = '0;
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD_CYC);
        end
      end
      ST_HOLD: begin
        if (tmr_expire) begin
          if (row_idx_q == IDX_W'(NUM_SPIN)) begin
            state_d = ST_DONE;
          end else begin
            row_idx_d = row_idx_q + IDX_W'(1);
            state_d   = ST_WAIT_DATA;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        wwl_d   = '0;
      end
    endcase

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      wwl_d    = '0;
      wbl_d    = '0;
      tmr_load = 1'b1;
      tmr_val  = '0;
    end

    ready_d = (state_d == ST_WAIT_DATA);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers; reset clears the lines immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      row_idx_q <= '0;
      wwl_q     <= '0;
      wbl_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      wwl_q     <= wwl_d;
      wbl_q     <= wbl_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign row_ready_o = ready_q;
  assign wwl_o       = wwl_q;
  assign wbl_o       = wbl_q;
  assign row_idx_o   = row_idx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_galena_write_sched.sv
// Directed bench for galena_write_sched with a 4-spin, 1/2/1-cycle configuration.
module tb_galena_write_sched;

  localparam int NS = 4;
  localparam int BD = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              abort_i;
  logic [NS*BD-1:0]  row_data_i;
  logic              row_valid_i;
  logic              row_ready_o;
  logic [NS:0]       wwl_o;
  logic [NS*BD-1:0]  wbl_o;
  logic [2:0]        row_idx_o;
  logic              busy_o;
  logic              done_o;

  int checks   = 0;
  int failures = 0;

  galena_write_sched #(
    .NUM_SPIN  (NS),
    .BIT_DATA  (BD),
    .SETUP_CYC (1),
    .PULSE_CYC (2),
    .HOLD_CYC  (1)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .row_data_i  (row_data_i),
    .row_valid_i (row_valid_i),
    .row_ready_o (row_ready_o),
    .wwl_o       (wwl_o),
    .wbl_o       (wbl_o),
    .row_idx_o   (row_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Full load; each row is WAIT, SETUP, PULSE, PULSE, HOLD (5 cycles).
  // Edge k counts from the start edge (k=1); DONE is seen after edge 26.
  task automatic run_load(input string tag, input bit stall, input bit noise);
    int kk, r, ph;
    logic [NS:0]      e_wwl;
    logic [2:0]       e_idx;
    logic             e_rdy, e_busy, e_done;
    start_i     = 1'b1;
    row_valid_i = 1'b1;
    row_data_i  = 16'h0001;
    for (int k = 1; k <= 30; k++) begin
      step();
      kk = k;
      if (stall && k >= 12) kk = (k <= 14) ? 11 : k - 3;
      r  = (kk - 1) / 5;
      ph = (kk - 1) % 5;
      e_wwl  = (kk <= 25 && (ph == 2 || ph == 3)) ? (5'b00001 << r) : 5'b00000;
      e_rdy  = (kk <= 25 && ph == 0);
      e_busy = (kk <= 26);
      e_done = (kk == 26);
      e_idx  = (kk <= 25) ? 3'(r) : 3'd4;
      checks++;
      if (wwl_o !== e_wwl) begin
        failures++;
        $display("FAIL %s wwl k=%0d got=%b exp=%b", tag, k, wwl_o, e_wwl);
      end
      checks++;
      if (row_ready_o !== e_rdy) begin
        failures++;
        $display("FAIL %s ready k=%0d got=%b exp=%b", tag, k, row_ready_o, e_rdy);
      end
      checks++;
      if (busy_o !== e_busy) begin
        failures++;
        $display("FAIL %s busy k=%0d got=%b exp=%b", tag, k, busy_o, e_busy);
      end
      checks++;
      if (done_o !== e_done) begin
        failures++;
        $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, done_o, e_done);
      end
      checks++;
      if (row_idx_o !== e_idx) begin
        failures++;
        $display("FAIL %s row_idx k=%0d got=%0d exp=%0d", tag, k, row_idx_o, e_idx);
      end
      if (kk <= 25 && ph != 0) begin
        checks++;
        if (wbl_o !== 16'(r + 1)) begin
          failures++;
          $display("FAIL %s wbl k=%0d got=%h exp=%h", tag, k, wbl_o, 16'(r + 1));
        end
      end
      // Real data only while waiting; garbage elsewhere must be ignored
      row_valid_i = !(stall && k >= 11 && k <= 13);
      row_data_i  = (kk <= 25 && ph == 0) ? 16'(r + 1) : 16'hDEAD;
      start_i     = noise && (k <= 20);
    end
    start_i     = 1'b0;
    row_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; abort_i = 1'b0;
    row_valid_i = 1'b1; row_data_i = 16'hFFFF;
    step(); step();
    checks++;
    if (wwl_o !== 5'b0)  begin failures++; $display("FAIL reset wwl got=%b exp=0", wwl_o); end
    checks++;
    if (wbl_o !== 16'h0) begin failures++; $display("FAIL reset wbl got=%h exp=0", wbl_o); end
    checks++;
    if (row_idx_o !== 3'd0) begin failures++; $display("FAIL reset row_idx got=%0d exp=0", row_idx_o); end
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || row_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset ctl busy=%b done=%b ready=%b exp=000", busy_o, done_o, row_ready_o);
    end
    start_i = 1'b0; row_valid_i = 1'b0; row_data_i = '0;
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_full_load();
    run_load("full_load", 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_load("stall", 1'b1, 1'b0);
  endtask

  task automatic test_start_busy();
    run_load("start_busy", 1'b0, 1'b1);
  endtask

  // Abort in the second PULSE cycle of row 3 (edge 19)
  task automatic test_abort();
    int r, ph;
    start_i = 1'b1; row_valid_i = 1'b1; row_data_i = 16'h0001;
    for (int k = 1; k <= 19; k++) begin
      step();
      start_i = 1'b0;
      r  = (k - 1) / 5;
      ph = (k - 1) % 5;
      row_data_i = (ph == 0) ? 16'(r + 1) : 16'hDEAD;
    end
    checks++;
    if (wwl_o !== 5'b01000) begin failures++; $display("FAIL abort pre wwl got=%b exp=01000", wwl_o); end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    checks++;
    if (wwl_o !== 5'b0 || wbl_o !== 16'h0) begin
      failures++;
      $display("FAIL abort lines wwl=%b wbl=%h exp=0/0", wwl_o, wbl_o);
    end
    checks++;
    if (busy_o !== 1'b0 || row_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL abort idle busy=%b ready=%b exp=0/0", busy_o, row_ready_o);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || wwl_o !== 5'b0) begin
        failures++;
        $display("FAIL abort after k=%0d done=%b busy=%b wwl=%b exp=0", k, done_o, busy_o, wwl_o);
      end
    end
    row_valid_i = 1'b0;
  endtask

  // Reset between edges while row 0 is pulsing
  task automatic test_async_reset();
    start_i = 1'b1; row_valid_i = 1'b1; row_data_i = 16'h0001;
    step();
    start_i = 1'b0;
    step(); step();
    checks++;
    if (wwl_o !== 5'b00001) begin failures++; $display("FAIL arst pre wwl got=%b exp=00001", wwl_o); end
    #3;
    rst_i = 1'b1;
    #1;
    checks++;
    if (wwl_o !== 5'b0) begin failures++; $display("FAIL arst wwl got=%b exp=0", wwl_o); end
    checks++;
    if (busy_o !== 1'b0 || row_ready_o !== 1'b0 || done_o !== 1'b0 ||
        wbl_o !== 16'h0 || row_idx_o !== 3'd0) begin
      failures++;
      $display("FAIL arst ctl busy=%b ready=%b done=%b wbl=%h idx=%0d exp=0",
               busy_o, row_ready_o, done_o, wbl_o, row_idx_o);
    end
    #1;
    rst_i = 1'b0;
    row_valid_i = 1'b0;
    step();
    run_load("post_reset", 1'b0, 1'b0);
  endtask

  // Transfer and abort in the same cycle
  task automatic test_abort_transfer();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    checks++;
    if (row_ready_o !== 1'b1) begin failures++; $display("FAIL abort_xfer ready got=%b exp=1", row_ready_o); end
    row_valid_i = 1'b1; row_data_i = 16'hABCD; abort_i = 1'b1;
    step();
    abort_i = 1'b0; row_valid_i = 1'b0;
    checks++;
    if (wbl_o !== 16'h0 || wwl_o !== 5'b0) begin
      failures++;
      $display("FAIL abort_xfer lines wbl=%h wwl=%b exp=0/0", wbl_o, wwl_o);
    end
    checks++;
    if (busy_o !== 1'b0 || row_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_xfer idle busy=%b ready=%b exp=0/0", busy_o, row_ready_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_abort();
    test_start_busy();
    test_async_reset();
    test_abort_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
